// File: rtl/spine_pkg.sv
// Shared header layout, route function and constants for the spine router.
package spine_pkg;

    // Routing header occupies the top HDR_W bits of every flit: group then leaf.
    localparam int GROUP_W    = 4;
    localparam int LEAF_W     = 2;
    localparam int HDR_W      = GROUP_W + LEAF_W;
    localparam int GROUP_LSB  = LEAF_W;
    localparam int LEAF_LSB   = 0;
    localparam int PORT_IDX_W = 8;

    // drop_count sticks here instead of wrapping.
    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    typedef struct packed {
        logic                  unroutable;
        logic [PORT_IDX_W-1:0] port;
    } route_t;

    // Maps a flit header to an egress port. Remote groups skip our own group
    // number so the inter-group ports are packed with no hole.
    function automatic route_t route_port(
        input logic [HDR_W-1:0]   flit_hdr,
        input logic [GROUP_W-1:0] group_id,
        input int                 num_leaf,
        input int                 num_group
    );
        route_t r;
        int     grp;
        int     leaf;
        int     p;
        grp  = int'(flit_hdr[GROUP_LSB +: GROUP_W]);
        leaf = int'(flit_hdr[LEAF_LSB +: LEAF_W]);
        if (grp == int'(group_id)) begin
            p            = leaf;
            r.unroutable = (leaf >= num_leaf);
        end else begin
            p            = num_leaf + ((grp < int'(group_id)) ? grp : grp - 1);
            r.unroutable = (p >= num_leaf + num_group);
        end
        r.port = p[PORT_IDX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input synchronous FIFO with registered full/empty flags and occupancy count.
module router_fifo #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));

    // Storage array is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spine_router_xbar.sv
// Group spine crossbar: per-input FIFOs, header routing, per-output round-robin
// arbitration into a single output register, and a saturating drop counter.
module spine_router_xbar
    import spine_pkg::*;
#(
    parameter logic [3:0] GROUP_ID   = 4'b0111,
    parameter int         NUM_LEAF   = 4,
    parameter int         NUM_GROUP  = 7,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    localparam int        NUM_PORTS  = NUM_LEAF + NUM_GROUP
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS*DWIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [15:0]                   drop_count
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = PORT_IDX_W - PW;

    logic [DWIDTH-1:0]       head_data [NUM_PORTS];
    route_t                  head_route [NUM_PORTS];
    logic [NUM_PORTS-1:0]    fifo_full;
    logic [NUM_PORTS-1:0]    fifo_empty;
    logic [NUM_PORTS-1:0]    fifo_push;
    logic [NUM_PORTS-1:0]    fifo_pop;
    logic [NUM_PORTS-1:0]    head_drop;
    logic [NUM_PORTS-1:0]    req [NUM_PORTS];
    logic [NUM_PORTS-1:0]    grant_valid;
    logic [PW-1:0]           grant_idx [NUM_PORTS];
    logic [PW-1:0]           rr [NUM_PORTS];
    logic [NUM_PORTS*CW-1:0] fifo_count_flat;
    logic [NUM_PORTS*HW-1:0] route_hi_flat;
    logic                    unused_bits;
    logic [15:0]             drop_count_q;
    logic [15:0]             drop_count_d;

    // in_ready comes straight from the registered full flag, never from out_ready.
    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    // One FIFO and one route decoder per ingress port.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        router_fifo #(
            .DWIDTH     (DWIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[i]),
            .push_data (in_data[i*DWIDTH +: DWIDTH]),
            .pop       (fifo_pop[i]),
            .head_data (head_data[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .count     (fifo_count_flat[i*CW +: CW])
        );
        assign head_route[i] = route_port(head_data[i][DWIDTH-1 -: HDR_W],
                                          GROUP_ID, NUM_LEAF, NUM_GROUP);
        assign route_hi_flat[i*HW +: HW] = head_route[i].port[PORT_IDX_W-1:PW];
    end

    // Occupancy counts and high port bits are not needed by the datapath.
    assign unused_bits = ^{fifo_count_flat, route_hi_flat};

    // Turn each non-empty head into either a one-hot output request or a drop.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i]       = '0;
            head_drop[i] = 1'b0;
            if (!fifo_empty[i]) begin
                if (head_route[i].unroutable) begin
                    head_drop[i] = 1'b1;
                end else begin
                    req[i][head_route[i].port[PW-1:0]] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick per output, only when its register can take a flit.
    always_comb begin
        int cand;
        cand = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_valid[o] = 1'b0;
            grant_idx[o]   = '0;
            if (!out_valid[o] || out_ready[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    cand = int'(rr[o]) + k;
                    if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
                    if (!grant_valid[o] && req[cand][o]) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = cand[PW-1:0];
                    end
                end
            end
        end
    end

    // A head leaves its FIFO when dropped or granted; routes are unique so at most one grant per input.
    always_comb begin
        fifo_pop = head_drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_valid[o]) fifo_pop[grant_idx[o]] = 1'b1;
        end
    end

    // Output register and round-robin pointer for each egress port.
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic              valid_q;
        logic [DWIDTH-1:0] data_q;
        logic [PW-1:0]     rr_q;

        // Load on grant, clear on drain; data holds until the downstream accepts it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                rr_q    <= '0;
            end else if (grant_valid[o]) begin
                valid_q <= 1'b1;
                data_q  <= head_data[grant_idx[o]];
                rr_q    <= (grant_idx[o] == PW'(NUM_PORTS-1)) ? '0 : grant_idx[o] + PW'(1);
            end else if (out_ready[o]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[o]                    = valid_q;
        assign out_data[o*DWIDTH +: DWIDTH]    = data_q;
        assign rr[o]                           = rr_q;
    end

    // Add every head dropped this cycle, clamping at the saturation value.
    always_comb begin
        int          n_drop;
        logic [16:0] sum;
        n_drop = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            n_drop = n_drop + int'(head_drop[i]);
        end
        sum = {1'b0, drop_count_q} + 17'(n_drop);
        drop_count_d = (sum > {1'b0, DROP_SAT}) ? DROP_SAT : sum[15:0];
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

endmodule
